pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
- Fetch-stage sequencer for the mips32 core.
- Owns the architectural fetch PC and drives the instruction-memory request/acknowledge handshake.
- Applies branch/jump redirects and decode back-pressure, and presents one buffered instruction per accepted fetch to the IF/ID boundary.
- Replaces the combinational enable/hold PC scheme with a clocked, handshake-safe controller.

Parameters:
- RESET_VECTOR, 32'h0000_0000, fetch address loaded on reset; must be word aligned.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  decode cannot accept; hold the IF output buffer.
- redirect_valid  in  1  single-cycle pulse; load a new PC (branch/jump/exception).
- redirect_target  in  32  new fetch address.
- imem_req  out  1  instruction-memory request, level-held until ack.
- imem_addr  out  32  fetch address; stable while imem_req=1.
- imem_ack  in  1  memory response valid; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- if_valid  out  1  if_instr/if_pc hold a live instruction.
- if_instr  out  32  buffered instruction.
- if_pc  out  32  address of if_instr.
- if_pc4  out  32  if_pc + PC_STEP, for link/branch computation.
- align_err  out  1  one-cycle pulse: redirect target was not word aligned.

Behaviour:
- Reset (synchronous, any state):
  - pc=RESET_VECTOR, state=BOOT, imem_req=0, if_valid=0, if_instr=0, if_pc=0, if_pc4=0, align_err=0.
  - An outstanding memory request is abandoned; the memory side is reset by the same reset.
- States:
  - BOOT: one cycle, imem_req=0 -> FETCH. First imem_req=1 in the 2nd cycle after reset deasserts.
  - FETCH: imem_req=1, imem_addr=pc.
    - On imem_ack, no redirect: if_instr<=imem_rdata, if_pc<=pc, if_pc4<=pc+4, if_valid<=1, pc<=pc+4.
    - Next state after that ack: FETCH, unless the new buffer is about to be held (stall=1), then HOLD.
    - Zero-wait ack (same cycle req rises) is legal.
  - HOLD: imem_req=0; buffer frozen while stall=1; stall=0 -> buffer consumed, if_valid<=0, -> FETCH.
  - DRAIN: imem_req=1 held at the old address until imem_ack; data discarded; if_valid stays 0 -> FETCH (pc already = target).
- Buffer consumption: if_valid=1 and stall=0 at an edge means decode took the instruction. A new ack the same cycle overwrites the buffer; back-to-back throughput is 1 instr/cycle with zero-wait memory.
- Request gating: FETCH never raises imem_req while if_valid=1 and stall=1 (buffer full); it moves to HOLD instead. Once asserted, imem_req is never dropped before ack, except on reset.
- Redirect (priority over stall and sequential fetch):
  - pc<=redirect_target & ~32'h3; if_valid<=0 next cycle.
  - align_err<=1 for one cycle if redirect_target[1:0]!=0.
  - FETCH, request outstanding, no ack this cycle -> DRAIN.
  - FETCH with ack in the same cycle -> data discarded, -> FETCH at target.
  - HOLD or BOOT -> FETCH at target.
  - DRAIN -> stay in DRAIN, pc updated; the latest redirect wins.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0 with no flag.
- imem_addr is always pc; pc[1:0] is always 0.

Decomposition:
- Shared package/header mips32_pkg: FSM state encoding (BOOT, FETCH, HOLD, DRAIN, 2 bits), PC_STEP, default RESET_VECTOR, word-align mask.
- One natural sub-module: if_buffer (the if_valid/if_instr/if_pc/if_pc4 register with load/hold/clear controls). The FSM and pc register stay in pc_fetch_ctrl.

Test Plan:
- Reset then zero-wait memory (ack whenever req), stall=0 -> if_pc = 0,4,8,12 on consecutive cycles; first if_valid=1 in cycle 3 after reset release.
- Memory ack latency 2, stall=0 -> imem_addr holds 0x0 for 3 cycles, if_instr = word@0, then imem_addr=0x4; imem_addr never changes while req=1 and ack=0.
- stall=1 for 3 cycles with if_valid=1, if_pc=0x8 -> buffer frozen, imem_req=0 during HOLD; stall drop -> fetch resumes at 0xC, no instruction lost or duplicated.
- redirect_valid with target 0x100 while a 3-cycle fetch of 0x10 is pending -> req held on 0x10 until ack; that data is not presented (if_valid=0); next request at 0x100.
- redirect (target 0x200) in the same cycle as ack for 0x20 -> 0x20 discarded, next if_pc=0x200; separately, target 0x203 -> align_err pulses 1 cycle, fetch at 0x200.
- RESET_VECTOR=32'hFFFF_FFF8 -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; reset asserted mid-DRAIN -> imem_req=0 next cycle, pc=RESET_VECTOR.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared fetch-stage definitions for the mips32 core: FSM encoding, PC defaults
// and the IF/ID buffer entry layout.
package mips32_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP_DEF      = 32'd4;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } if_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & WORD_MASK;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if_buffer.sv
// IF/ID output register: one buffered instruction with its PC and PC+step.
// Load wins over clear; clear only drops the valid bit.
module if_buffer
  import mips32_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      load,
  input  logic      clear,
  input  if_entry_t ent_in,
  output logic      valid,
  output if_entry_t ent
);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      ent   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ent   <= ent_in;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, runs the imem req/ack handshake,
// applies redirects and decode back-pressure, and feeds the IF/ID buffer.
module pc_fetch_ctrl
  import mips32_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] PC_STEP      = PC_STEP_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        align_err
);

  fetch_state_e state, state_nx;
  logic [31:0]  pc, pc_nx, pc_seq, drain_addr;
  logic         ack, buf_load, buf_clear;
  if_entry_t    ent_in, ent;

  assign pc_seq = pc + PC_STEP;

  // A full buffer that decode is stalling on must not launch a new fetch.
  assign imem_req = (state == DRAIN) || ((state == FETCH) && !(if_valid && stall));
  assign ack      = imem_req && imem_ack;

  // pc moves to the redirect target immediately, but the abandoned request
  // must keep its address stable until memory acknowledges it.
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;

  assign ent_in = '{instr: imem_rdata, pc: pc, pc4: pc_seq};

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    case (state)
      BOOT:  state_nx = FETCH;
      FETCH: begin
        if (!imem_req) begin
          state_nx = HOLD;
        end else begin
          buf_clear = if_valid && !stall;
          if (ack) begin
            buf_load = 1'b1;
            pc_nx    = pc_seq;
            state_nx = stall ? HOLD : FETCH;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          buf_clear = 1'b1;
          state_nx  = FETCH;
        end
      end
      DRAIN:   if (ack) state_nx = FETCH;
      default: state_nx = BOOT;
    endcase

    // Redirect overrides stall and sequential fetch; any in-flight data is stale.
    if (redirect_valid) begin
      pc_nx     = word_align(redirect_target);
      buf_load  = 1'b0;
      buf_clear = 1'b1;
      if (state == DRAIN)                          state_nx = ack ? FETCH : DRAIN;
      else if (state == FETCH && imem_req && !ack) state_nx = DRAIN;
      else                                         state_nx = FETCH;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= BOOT;
      pc         <= word_align(RESET_VECTOR);
      drain_addr <= word_align(RESET_VECTOR);
      align_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      align_err <= redirect_valid && (redirect_target[1:0] != 2'b00);
      if (state != DRAIN) drain_addr <= pc;
    end
  end

  if_buffer u_buf (
    .clock  (clock),
    .reset  (reset),
    .load   (buf_load),
    .clear  (buf_clear),
    .ent_in (ent_in),
    .valid  (if_valid),
    .ent    (ent)
  );

  assign if_instr = ent.instr;
  assign if_pc    = ent.pc;
  assign if_pc4   = ent.pc4;

endmodule
